pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_pkg.sv | 7 +
 rtl/hazard_match.sv | 13 +
 rtl/pipe_hazard_unit.sv | 113 +++++++++++
 tb/tb_pipe_hazard_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM states and forward-select encodings for pipe_hazard_unit
package pipe_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_e;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: one source/producer register-address compare, optional hardwired-zero register
module hazard_match #(
  parameter int REG_AW   = 4,
  parameter bit ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic [REG_AW-1:0] dst,
  input  logic              dst_we,
  output logic              hit
);
  assign hit = src_used && dst_we && src == dst && !(ZERO_REG && dst == '0);
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: pipeline stall/flush/forward control with data-memory wait and halt.
// Define PIPE_HAZARD_FWD_EN for operand forwarding; otherwise EX/MEM producers interlock.
module pipe_hazard_unit import pipe_pkg::*; #(
  parameter int REG_AW   = 4,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memop,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  input  logic              halt_in,
  input  logic              dm_ack,
  output logic              pc_wr,
  output logic              if_id_wr,
  output logic              id_ex_wr,
  output logic              ex_mem_wr,
  output logic              mem_wb_wr,
  output logic              if_id_clr,
  output logic              id_ex_clr,
  output logic              ex_mem_clr,
  output logic              mem_wb_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              dm_req,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_e state_q, state_d;
  logic branch_q, branch_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0][REG_AW-1:0] src;
  logic [2:0][REG_AW-1:0] dst;
  logic [1:0] src_used;
  logic [2:0] dst_we;
  logic [1:0][2:0] hit;
  logic hz, wait_c, flush, stall, adv;
  logic [1:0] fa, fb;

  assign src      = {id_rt, id_rs};
  assign src_used = {id_rt_used, id_rs_used};
  assign dst      = {wb_rd, mem_rd, ex_rd};
  assign dst_we   = {wb_regwrite, mem_regwrite, ex_regwrite};

  // hit[s][p]: s = rs/rt, p = EX, MEM, WB producer
  for (genvar s = 0; s < 2; s++) begin : g_s
    for (genvar p = 0; p < 3; p++) begin : g_p
      hazard_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_match (
        .src(src[s]), .src_used(src_used[s]), .dst(dst[p]), .dst_we(dst_we[p]), .hit(hit[s][p])
      );
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  assign hz = ex_memread && (hit[0][0] || hit[1][0]);
  assign fa = hit[0][1] ? FWD_MEM : hit[0][2] ? FWD_WB : FWD_RF;
  assign fb = hit[1][1] ? FWD_MEM : hit[1][2] ? FWD_WB : FWD_RF;
`else
  // register file writes through, so a WB producer needs neither stall nor forward
  logic unused_wb;
  assign unused_wb = ex_memread ^ hit[0][2] ^ hit[1][2];
  assign hz = hit[0][0] || hit[1][0] || hit[0][1] || hit[1][1];
  assign fa = FWD_RF;
  assign fb = FWD_RF;
`endif

  always_comb begin
    wait_c = state_q == MEM_WAIT ? !dm_ack : state_q == RUN && mem_memop && !dm_ack;
    adv = state_q != HALTED && !wait_c;
    flush = adv && (branch_taken || branch_q);
    stall = state_q == RUN && !wait_c && !flush && hz;
    state_d = halt_in || state_q == HALTED ? HALTED : wait_c ? MEM_WAIT : RUN;
    branch_d = wait_c && (branch_q || branch_taken);
    stall_cnt_d = (wait_c || stall) && stall_cnt_q != '1 ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    pc_wr = !rst_n || (adv && !stall);
    if_id_wr = pc_wr;
    id_ex_wr = !rst_n || adv;
    ex_mem_wr = id_ex_wr;
    mem_wb_wr = id_ex_wr;
    if_id_clr = rst_n && flush;
    id_ex_clr = rst_n && (flush || stall);
    ex_mem_clr = if_id_clr;
    mem_wb_clr = 1'b0;
    dm_req = rst_n && (state_q == MEM_WAIT || (state_q == RUN && mem_memop));
    halted = state_q == HALTED;
    fwd_a = rst_n ? fa : FWD_RF;
    fwd_b = rst_n ? fb : FWD_RF;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      branch_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      branch_q <= branch_d;
      stall_cnt_q <= stall_cnt_d;
    end

  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vector table plus multi-cycle sequences for pipe_hazard_unit
module tb_pipe_hazard_unit;
`ifdef PIPE_HAZARD_FWD_EN
  localparam bit F = 1;
`else
  localparam bit F = 0;
`endif
  typedef struct packed {
    logic [3:0] rs, rt;
    logic rs_u, rt_u;
    logic [3:0] ex_rd;
    logic ex_rw, ex_mr;
    logic [3:0] mem_rd;
    logic mem_rw, mem_op;
    logic [3:0] wb_rd;
    logic wb_rw, br, halt, ack;
  } vin_t;
  typedef struct {
    string n;
    vin_t i;
    logic [10:0] o;
    logic [1:0] fa, fb;
  } vec_t;
  // {pc, if_id, id_ex, ex_mem, mem_wb wr; if_id, id_ex, ex_mem, mem_wb clr; dm_req; halted}
  localparam logic [10:0] NORM     = 11'b11111_0000_0_0;
  localparam logic [10:0] STALL    = 11'b00111_0100_0_0;
  localparam logic [10:0] FLUSH    = 11'b11111_1110_0_0;
  localparam logic [10:0] FREEZE   = 11'b00000_0000_1_0;
  localparam logic [10:0] HALT     = 11'b00000_0000_0_1;
  localparam logic [10:0] NORM_DM  = 11'b11111_0000_1_0;
  localparam logic [10:0] FLUSH_DM = 11'b11111_1110_1_0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_rs_used, id_rt_used, ex_regwrite, ex_memread, mem_regwrite, mem_memop, wb_regwrite;
  logic branch_taken, halt_in, dm_ack;
  logic pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
  logic if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, dm_req, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic [10:0] outs;
  int n_cmp = 0, n_bad = 0;
  vec_t tab[$];
  vin_t z, lu, mw, mwa, t;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memop(mem_memop), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .halt_in(halt_in), .dm_ack(dm_ack), .pc_wr(pc_wr), .if_id_wr(if_id_wr),
    .id_ex_wr(id_ex_wr), .ex_mem_wr(ex_mem_wr), .mem_wb_wr(mem_wb_wr), .if_id_clr(if_id_clr),
    .id_ex_clr(id_ex_clr), .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dm_req(dm_req), .halted(halted), .stall_cnt(stall_cnt)
  );

  assign outs = {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, dm_req, halted};

  function automatic vin_t vi(int rs, rt, us, ut, exrd, exrw, exmr, memrd, memrw, memop, wbrd, wbrw, br, ack);
    vin_t v;
    v = '0;
    v.rs = 4'(rs); v.rt = 4'(rt); v.rs_u = us[0]; v.rt_u = ut[0];
    v.ex_rd = 4'(exrd); v.ex_rw = exrw[0]; v.ex_mr = exmr[0];
    v.mem_rd = 4'(memrd); v.mem_rw = memrw[0]; v.mem_op = memop[0];
    v.wb_rd = 4'(wbrd); v.wb_rw = wbrw[0]; v.br = br[0]; v.ack = ack[0];
    return v;
  endfunction

  task automatic drive(input vin_t v);
    id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rs_u; id_rt_used = v.rt_u;
    ex_rd = v.ex_rd; ex_regwrite = v.ex_rw; ex_memread = v.ex_mr;
    mem_rd = v.mem_rd; mem_regwrite = v.mem_rw; mem_memop = v.mem_op;
    wb_rd = v.wb_rd; wb_regwrite = v.wb_rw; branch_taken = v.br; halt_in = v.halt; dm_ack = v.ack;
  endtask

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step(input string n, input vin_t v, input logic [10:0] o, input logic [1:0] fa, input logic [1:0] fb);
    drive(v);
    @(negedge clk);
    cmp({n, " outs"}, 32'(outs), 32'(o));
    cmp({n, " fwd"}, 32'({fwd_a, fwd_b}), 32'({fa, fb}));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string n);
    rst_n = 1'b0;
    drive(vi(3, 7, 1, 1, 3, 1, 1, 7, 1, 1, 0, 0, 1, 0));
    #2;
    cmp({n, " rst outs"}, 32'(outs), 32'(NORM));
    cmp({n, " rst fwd"}, 32'({fwd_a, fwd_b}), 32'(0));
    cmp({n, " rst cnt"}, 32'(stall_cnt), 32'(0));
    drive('0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    z = '0;
    lu = vi(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    mw = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    mwa = mw; mwa.ack = 1'b1;
    tab.push_back('{"idle", z, NORM, 2'b00, 2'b00});
    tab.push_back('{"rt_mem_wb", vi(0, 5, 0, 1, 0, 0, 0, 5, 1, 0, 5, 1, 0, 0), F ? NORM : STALL, 2'b00, F ? 2'b10 : 2'b00});
    tab.push_back('{"rt_wb", vi(0, 5, 0, 1, 0, 0, 0, 5, 0, 0, 5, 1, 0, 0), NORM, 2'b00, F ? 2'b01 : 2'b00});
    tab.push_back('{"rt_zero", vi(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0), NORM, 2'b00, 2'b00});
    tab.push_back('{"rt_unused", vi(0, 5, 0, 0, 0, 0, 0, 5, 1, 0, 5, 1, 0, 0), NORM, 2'b00, 2'b00});
    tab.push_back('{"rs_mem_wb", vi(7, 0, 1, 0, 0, 0, 0, 7, 1, 0, 7, 1, 0, 0), F ? NORM : STALL, F ? 2'b10 : 2'b00, 2'b00});
    tab.push_back('{"rs_ex_alu", vi(2, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), F ? NORM : STALL, 2'b00, 2'b00});
    tab.push_back('{"load_use_rs", lu, STALL, 2'b00, 2'b00});
    tab.push_back('{"load_use_rt", vi(0, 3, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0), STALL, 2'b00, 2'b00});
    tab.push_back('{"load_no_we", vi(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0), NORM, 2'b00, 2'b00});
    tab.push_back('{"load_zero", vi(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), NORM, 2'b00, 2'b00});
    tab.push_back('{"flush_over_lu", vi(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 0), FLUSH, 2'b00, 2'b00});
    tab.push_back('{"memop_ack", mwa, NORM_DM, 2'b00, 2'b00});
    tab.push_back('{"mixed", vi(6, 9, 1, 1, 0, 0, 0, 6, 1, 0, 9, 1, 0, 0), F ? NORM : STALL, F ? 2'b10 : 2'b00, F ? 2'b01 : 2'b00});

    do_reset("init");
    foreach (tab[i]) step(tab[i].n, tab[i].i, tab[i].o, tab[i].fa, tab[i].fb);

    do_reset("lu");
    step("lu", lu, STALL, 2'b00, 2'b00);
    cmp("lu cnt", 32'(stall_cnt), 32'(1));
    step("lu_done", z, NORM, 2'b00, 2'b00);
    cmp("lu once cnt", 32'(stall_cnt), 32'(1));

    do_reset("mw");
    for (int i = 0; i < 3; i++) step("mw_wait", mw, FREEZE, 2'b00, 2'b00);
    step("mw_ack", mwa, NORM_DM, 2'b00, 2'b00);
    cmp("mw cnt", 32'(stall_cnt), 32'(3));
    step("mw_after", z, NORM, 2'b00, 2'b00);

    do_reset("br");
    step("br_lu", vi(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 0), FLUSH, 2'b00, 2'b00);
    cmp("br_lu cnt", 32'(stall_cnt), 32'(0));
    step("br_mw1", mw, FREEZE, 2'b00, 2'b00);
    t = mw; t.br = 1'b1;
    step("br_mw2", t, FREEZE, 2'b00, 2'b00);
    step("br_ack", mwa, FLUSH_DM, 2'b00, 2'b00);
    step("br_after", z, NORM, 2'b00, 2'b00);
    cmp("br cnt", 32'(stall_cnt), 32'(2));

    do_reset("halt");
    step("pre_halt", lu, STALL, 2'b00, 2'b00);
    t = z; t.halt = 1'b1;
    step("halt_in", t, NORM, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) step("halted", vi(3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0, 0, 1, 0), HALT, 2'b00, 2'b00);
    cmp("halted cnt", 32'(stall_cnt), 32'(1));
    do_reset("unhalt");
    step("post_halt", z, NORM, 2'b00, 2'b00);
    cmp("post_halt cnt", 32'(stall_cnt), 32'(0));

    step("mwh1", mw, FREEZE, 2'b00, 2'b00);
    t = mw; t.halt = 1'b1;
    step("mwh2", t, FREEZE, 2'b00, 2'b00);
    step("mwh3", mw, HALT, 2'b00, 2'b00);
    cmp("mwh cnt", 32'(stall_cnt), 32'(2));

    do_reset("rmw");
    step("rst_mw", mw, FREEZE, 2'b00, 2'b00);
    rst_n = 1'b0;
    #1;
    cmp("rst_mw dm_req", 32'(dm_req), 32'(0));
    cmp("rst_mw outs", 32'(outs), 32'(NORM));
    drive(z);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rst_mw_after", z, NORM, 2'b00, 2'b00);

    do_reset("il");
    step("il_ex", vi(4, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0), F ? NORM : STALL, 2'b00, 2'b00);
    step("il_mem", vi(4, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0), F ? NORM : STALL, F ? 2'b10 : 2'b00, 2'b00);
    step("il_wb", vi(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0), NORM, F ? 2'b01 : 2'b00, 2'b00);
    cmp("il cnt", 32'(stall_cnt), F ? 32'(0) : 32'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
